// File: rtl/aq_djpeg_pkg.sv
// Shared types for the JPEG decoder pixel output stage.
// State encodings, FIFO word layout and stream padding.
package aq_djpeg_pkg;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    localparam int PIX_W = 26;
    localparam logic [7:0] TDATA_PAD = 8'h00;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       tuser;
        logic       tlast;
    } pix_t;

endpackage

// File: rtl/aq_djpeg_sfifo.sv
// Small synchronous FIFO; head word is read straight from storage.
// Output word reads as zero while empty.
module aq_djpeg_sfifo #(
    parameter int DW = 26,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] dout
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == CNT_FULL);
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/aq_axis_djpeg_pixout.sv
// Raster-order RGB pixels to AXI4-Stream video with SOF/EOL markers,
// plus PIXELX/PIXELY progress and frame done/size error pulses.
module aq_axis_djpeg_pixout
    import aq_djpeg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic        ACLK,
    input  logic        RST,
    input  logic        START,
    input  logic [15:0] WIDTH,
    input  logic [15:0] HEIGHT,
    input  logic        DEC_VALID,
    output logic        DEC_READY,
    input  logic [7:0]  DEC_R,
    input  logic [7:0]  DEC_G,
    input  logic [7:0]  DEC_B,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TUSER,
    output logic        M_AXIS_TLAST,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [15:0] PIXELX,
    output logic [15:0] PIXELY,
    output logic        IDLE,
    output logic        FRAME_DONE,
    output logic        SIZE_ERR
);

    if (FIFO_DEPTH != (1 << FIFO_AW)) begin : g_bad_depth
        $error("FIFO_DEPTH must equal 2**FIFO_AW");
    end

    state_e      state_q, state_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [15:0] wm1_q, wm1_d;
    logic [15:0] hm1_q, hm1_d;
    logic        size_err_q, size_err_d;
    logic        frame_done;

    logic        fifo_full, fifo_empty;
    logic        accept, pop;
    pix_t        push_pix, head;
    logic [PIX_W-1:0] fifo_dout;

    assign DEC_READY = (state_q == S_RUN) && !fifo_full;
    assign accept    = DEC_VALID & DEC_READY;
    assign pop       = M_AXIS_TVALID & M_AXIS_TREADY;

    assign push_pix.r     = DEC_R;
    assign push_pix.g     = DEC_G;
    assign push_pix.b     = DEC_B;
    assign push_pix.tuser = (x_q == 16'd0) && (y_q == 16'd0);
    assign push_pix.tlast = (x_q == wm1_q);

    aq_djpeg_sfifo #(
        .DW (PIX_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (ACLK),
        .rst   (RST),
        .push  (accept),
        .din   (push_pix),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    assign head          = pix_t'(fifo_dout);
    assign M_AXIS_TVALID = !fifo_empty;
    assign M_AXIS_TDATA  = {TDATA_PAD, head.r, head.g, head.b};
    assign M_AXIS_TUSER  = head.tuser;
    assign M_AXIS_TLAST  = head.tlast;

    assign PIXELX     = x_q;
    assign PIXELY     = y_q;
    assign IDLE       = (state_q == S_WAIT);
    assign FRAME_DONE = frame_done;
    assign SIZE_ERR   = size_err_q;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        wm1_d      = wm1_q;
        hm1_d      = hm1_q;
        size_err_d = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            S_WAIT: begin
                if (START) begin
                    if (WIDTH != 16'd0 && HEIGHT != 16'd0) begin
                        wm1_d   = WIDTH - 16'd1;
                        hm1_d   = HEIGHT - 16'd1;
                        x_d     = 16'd0;
                        y_d     = 16'd0;
                        state_d = S_RUN;
                    end else begin
                        size_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (x_q == wm1_q) begin
                        x_d = 16'd0;
                        y_d = y_q + 16'd1;
                        if (y_q == hm1_q) state_d = S_FLUSH;
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                end
            end
            S_FLUSH: begin
                // Last beat has left once the FIFO drains.
                if (fifo_empty) begin
                    frame_done = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (RST) begin
            state_q    <= S_WAIT;
            x_q        <= '0;
            y_q        <= '0;
            wm1_q      <= '0;
            hm1_q      <= '0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            wm1_q      <= wm1_d;
            hm1_q      <= hm1_d;
            size_err_q <= size_err_d;
        end
    end

endmodule

// File: tb/tb_aq_axis_djpeg_pixout.sv
// Scoreboard bench for aq_axis_djpeg_pixout: driver pushes expected beats
// on accept, an independent monitor pops them as the stream emits.
module tb_aq_axis_djpeg_pixout;

    logic        ACLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [15:0] WIDTH = '0;
    logic [15:0] HEIGHT = '0;
    logic        DEC_VALID = 1'b0;
    logic        DEC_READY;
    logic [7:0]  DEC_R = '0;
    logic [7:0]  DEC_G = '0;
    logic [7:0]  DEC_B = '0;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TUSER;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY = 1'b0;
    logic [15:0] PIXELX;
    logic [15:0] PIXELY;
    logic        IDLE;
    logic        FRAME_DONE;
    logic        SIZE_ERR;

    int n_cmp = 0;
    int n_err = 0;
    logic [25:0] exp_q[$];
    int ready_mode = 0;
    int cyc = 0;
    int last_pop_cyc = -10;
    int fd_cnt = 0;

    aq_axis_djpeg_pixout #(
        .FIFO_DEPTH (4),
        .FIFO_AW    (2)
    ) dut (
        .ACLK          (ACLK),
        .RST           (RST),
        .START         (START),
        .WIDTH         (WIDTH),
        .HEIGHT        (HEIGHT),
        .DEC_VALID     (DEC_VALID),
        .DEC_READY     (DEC_READY),
        .DEC_R         (DEC_R),
        .DEC_G         (DEC_G),
        .DEC_B         (DEC_B),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TUSER  (M_AXIS_TUSER),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .PIXELX        (PIXELX),
        .PIXELY        (PIXELY),
        .IDLE          (IDLE),
        .FRAME_DONE    (FRAME_DONE),
        .SIZE_ERR      (SIZE_ERR)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Sink: TREADY policy selected by ready_mode.
    initial begin
        forever begin
            @(posedge ACLK);
            #1;
            case (ready_mode)
                0:       M_AXIS_TREADY = 1'b1;
                1:       M_AXIS_TREADY = 1'($urandom_range(0, 1));
                default: M_AXIS_TREADY = 1'b0;
            endcase
        end
    end

    // Monitor: stream beats against the scoreboard queue.
    initial begin
        logic [25:0] e;
        logic [25:0] held;
        logic        stall_p;
        stall_p = 1'b0;
        held = '0;
        forever begin
            @(negedge ACLK);
            cyc++;
            if (RST) begin
                exp_q.delete();
                stall_p = 1'b0;
            end else begin
                if (stall_p) begin
                    chk("hold_valid", 32'(M_AXIS_TVALID), 32'd1);
                    chk("hold_payload",
                        32'({M_AXIS_TDATA[23:0], M_AXIS_TUSER, M_AXIS_TLAST}),
                        32'(held));
                end
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL beat_unexpected: got %h required none",
                                 M_AXIS_TDATA);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat",
                            32'({M_AXIS_TDATA[23:0], M_AXIS_TUSER,
                                 M_AXIS_TLAST}), 32'(e));
                        chk("pad", 32'(M_AXIS_TDATA[31:24]), 32'd0);
                    end
                    last_pop_cyc = cyc;
                end
                stall_p = M_AXIS_TVALID && !M_AXIS_TREADY;
                held = {M_AXIS_TDATA[23:0], M_AXIS_TUSER, M_AXIS_TLAST};
                if (FRAME_DONE) begin
                    fd_cnt++;
                    chk("done_q_empty", 32'(exp_q.size()), 32'd0);
                    chk("done_timing", 32'(cyc), 32'(last_pop_cyc + 1));
                end
            end
        end
    end

    function automatic logic [23:0] pix_val(input bit seq, input int n);
        if (seq) return {8'(3*n+1), 8'(3*n+2), 8'(3*n+3)};
        return 24'($urandom);
    endfunction

    task automatic run_frame(input int w, input int h, input bit seq,
                             input bit stall, input bit allv,
                             input int mid_at, input int abort_at);
        logic [23:0] cur;
        int n;
        int t;
        int fd0;
        bit got;
        n = 0;
        t = 0;
        cur = pix_val(seq, 0);
        if (stall) ready_mode = 2;
        @(posedge ACLK);
        #1;
        START = 1'b1;
        WIDTH = 16'(w);
        HEIGHT = 16'(h);
        @(posedge ACLK);
        #1;
        START = 1'b0;
        WIDTH = 16'($urandom);
        HEIGHT = 16'($urandom);
        while (n < w*h && t < 3000) begin
            DEC_VALID = (allv || stall) ? 1'b1 : ($urandom_range(0, 3) != 0);
            {DEC_R, DEC_G, DEC_B} = cur;
            START = (mid_at > 0 && n == mid_at);
            if (START) WIDTH = 16'(w + 3);
            @(negedge ACLK);
            if (DEC_VALID && DEC_READY) begin
                chk("pixelx", 32'(PIXELX), 32'(n % w));
                chk("pixely", 32'(PIXELY), 32'(n / w));
                exp_q.push_back({cur, n == 0, (n % w) == w - 1});
                n++;
                cur = pix_val(seq, n);
            end
            if (stall && t == 12) begin
                chk("stall_accepts", 32'(n), 32'd4);
                chk("stall_ready", 32'(DEC_READY), 32'd0);
                chk("stall_tdata", M_AXIS_TDATA, 32'h00010203);
                ready_mode = 0;
            end
            t++;
            if (abort_at > 0 && n == abort_at) break;
            @(posedge ACLK);
            #1;
        end
        START = 1'b0;
        if (abort_at > 0) begin
            @(posedge ACLK);
            #1;
            DEC_VALID = 1'b0;
            RST = 1'b1;
            fd0 = fd_cnt;
            @(posedge ACLK);
            #1;
            RST = 1'b0;
            @(negedge ACLK);
            chk("abort_tvalid", 32'(M_AXIS_TVALID), 32'd0);
            chk("abort_px", 32'(PIXELX), 32'd0);
            chk("abort_py", 32'(PIXELY), 32'd0);
            chk("abort_idle", 32'(IDLE), 32'd1);
            repeat (20) @(negedge ACLK);
            chk("abort_no_done", 32'(fd_cnt), 32'(fd0));
            return;
        end
        chk("accept_budget", 32'(t < 3000), 32'd1);
        @(posedge ACLK);
        #1;
        DEC_VALID = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge ACLK);
            if (FRAME_DONE) begin
                got = 1'b1;
                break;
            end
        end
        chk("frame_done_seen", 32'(got), 32'd1);
        @(negedge ACLK);
        chk("end_idle", 32'(IDLE), 32'd1);
        chk("end_done_low", 32'(FRAME_DONE), 32'd0);
        chk("end_px", 32'(PIXELX), 32'd0);
        chk("end_py", 32'(PIXELY), 32'(h));
        chk("end_ready", 32'(DEC_READY), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        RST = 1'b0;
        @(negedge ACLK);
        chk("rst_ready", 32'(DEC_READY), 32'd0);
        chk("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        chk("rst_tdata", M_AXIS_TDATA, 32'd0);
        chk("rst_tuser_tlast", 32'({M_AXIS_TUSER, M_AXIS_TLAST}), 32'd0);
        chk("rst_pix", 32'({PIXELX, PIXELY}), 32'd0);
        chk("rst_idle", 32'(IDLE), 32'd1);
        chk("rst_pulses", 32'({FRAME_DONE, SIZE_ERR}), 32'd0);

        ready_mode = 0;
        run_frame(4, 2, 1'b1, 1'b0, 1'b1, 0, 0);
        run_frame(4, 2, 1'b1, 1'b1, 1'b1, 0, 0);
        run_frame(1, 3, 1'b0, 1'b0, 1'b1, 0, 0);

        @(posedge ACLK);
        #1;
        START = 1'b1;
        WIDTH = 16'd0;
        HEIGHT = 16'd8;
        @(posedge ACLK);
        #1;
        START = 1'b0;
        @(negedge ACLK);
        chk("szerr_pulse", 32'(SIZE_ERR), 32'd1);
        chk("szerr_idle", 32'(IDLE), 32'd1);
        chk("szerr_ready", 32'(DEC_READY), 32'd0);
        @(negedge ACLK);
        chk("szerr_clear", 32'(SIZE_ERR), 32'd0);
        chk("szerr_still_idle", 32'(IDLE), 32'd1);

        run_frame(4, 4, 1'b0, 1'b0, 1'b1, 0, 5);
        run_frame(2, 2, 1'b0, 1'b0, 1'b0, 0, 0);
        run_frame(4, 3, 1'b0, 1'b0, 1'b1, 2, 0);

        for (int i = 0; i < 6; i++) begin
            ready_mode = (i % 2 == 1) ? 1 : 0;
            run_frame($urandom_range(1, 6), $urandom_range(1, 4),
                      1'b0, 1'b0, 1'b0, 0, 0);
        end
        ready_mode = 0;

        repeat (5) @(negedge ACLK);
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aq_axis_djpeg_pixout.md
Name: aq_axis_djpeg_pixout

Overview:
- Output stage directly downstream of the JPEG decode core. Takes decoded RGB pixels in raster order and emits them as an AXI4-Stream video stream with SOF (TUSER) and EOL (TLAST) markers.
- Generates the PIXELX/PIXELY progress coordinates read back through the AXI4-Lite control block.
- Frames are delimited by START, using WIDTH/HEIGHT latched from the decoded header.
- A small FIFO absorbs sink backpressure.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; power of two, >=2.
- FIFO_AW, 2, log2(FIFO_DEPTH).

Ports:
- ACLK  in  1  clock
- RST  in  1  reset; synchronous, active-high; driven from LOGIC_RST
- START  in  1  one-cycle pulse: latch WIDTH/HEIGHT, begin frame
- WIDTH  in  16  frame width in pixels
- HEIGHT  in  16  frame height in pixels
- DEC_VALID  in  1  decoder pixel valid
- DEC_READY  out  1  pixel accepted when DEC_VALID & DEC_READY
- DEC_R, DEC_G, DEC_B  in  8 each  pixel components
- M_AXIS_TDATA  out  32  {8'h00, R, G, B}
- M_AXIS_TUSER  out  1  start of frame (pixel 0,0)
- M_AXIS_TLAST  out  1  end of line
- M_AXIS_TVALID  out  1  stream valid
- M_AXIS_TREADY  in  1  stream ready
- PIXELX  out  16  x of next pixel to accept
- PIXELY  out  16  y of next pixel to accept
- IDLE  out  1  high in S_WAIT
- FRAME_DONE  out  1  one-cycle pulse when last pixel has left the stream
- SIZE_ERR  out  1  one-cycle pulse: START with WIDTH==0 or HEIGHT==0

Behaviour:
- Reset: state S_WAIT, FIFO empty, all counters 0.
- Reset output values: DEC_READY=0, M_AXIS_TVALID=0, TDATA/TUSER/TLAST=0, PIXELX=PIXELY=0, IDLE=1, FRAME_DONE=0, SIZE_ERR=0.
- RST asserted mid-frame aborts immediately: FIFO contents dropped, no FRAME_DONE.
- S_WAIT:
  - START with WIDTH!=0 and HEIGHT!=0: latch w_reg/h_reg, clear x/y, go to S_RUN.
  - START with either value zero: pulse SIZE_ERR next cycle, stay in S_WAIT.
- S_RUN:
  - DEC_READY = !fifo_full (combinational from registered FIFO count).
  - On accept: push {R,G,B, tuser=(x==0&&y==0), tlast=(x==w_reg-1)}.
  - If x==w_reg-1: x<=0 and y<=y+1; else x<=x+1.
  - Accept of pixel (w_reg-1, h_reg-1): go to S_FLUSH; x/y hold at (0,h_reg); DEC_READY=0 from the next cycle.
- S_FLUSH:
  - DEC_READY=0.
  - When the FIFO is empty and no beat is pending: FRAME_DONE=1 for one cycle, go to S_WAIT.
  - PIXELX/PIXELY keep their final value until the next START.
- START outside S_WAIT is ignored. WIDTH/HEIGHT changes after latch are ignored.
- Stream:
  - M_AXIS_TVALID = !fifo_empty; TDATA/TUSER/TLAST driven from the FIFO head.
  - Pop on TVALID & TREADY.
  - Once TVALID is asserted, the beat and its payload stay stable until TREADY.
- FIFO:
  - Simultaneous push and pop while full is not permitted (DEC_READY=0 when full).
  - Simultaneous push and pop at any other fill level leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: accepted pixel appears on M_AXIS_TVALID the next cycle when the FIFO was empty. Sustained throughput is 1 pixel/clock with TREADY=1.
- Arithmetic:
  - x, y are 16-bit. Comparisons use w_reg-1 and h_reg-1 computed once at latch.
  - WIDTH=1 gives TUSER and TLAST on the same beat; every beat then carries TLAST.

Decomposition:
- Package aq_djpeg_pkg: state encodings S_WAIT=2'd0, S_RUN=2'd1, S_FLUSH=2'd2; pixel word width 26 (24 data + tuser + tlast); TDATA pad constant 8'h00.
- Sub-module aq_djpeg_sfifo: synchronous FIFO.
  - Parameters: DW, AW.
  - Ports: push/pop, full/empty, dout registered at head.
  - Sync active-high reset.

Test Plan:
- 4x2 frame, TREADY=1, DEC_VALID=1 -> 8 beats. TUSER on beat 0 only; TLAST on beats 3 and 7. FRAME_DONE 1 cycle after last beat, then IDLE=1. PIXELX/PIXELY end at (0,2).
- 4x2 frame, TREADY held 0 -> DEC_READY drops after FIFO_DEPTH=4 accepts. TDATA stable at pixel 0 (R=01,G=02,B=03 -> 32'h00010203). Releasing TREADY drains in order.
- 1x3 frame -> 3 beats, each TLAST=1; TUSER only on the first.
- START with WIDTH=0, HEIGHT=8 -> SIZE_ERR pulse, IDLE stays 1, DEC_READY=0.
- RST after 5 of 16 pixels of a 4x4 frame -> next cycle TVALID=0, PIXELX=PIXELY=0, IDLE=1, no FRAME_DONE. A new 2x2 frame then completes normally.
- START pulsed during S_RUN with different WIDTH -> ignored; frame completes with the original line length.
